// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM encoding and the linear round-transform helpers.
package aes_pkg;

    localparam int unsigned NR    = 10;
    localparam int unsigned BLK_W = 128;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} aes_fsm_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte k of the block sits at [127-8k -: 8]; row r, column c is byte r+4c.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES encryption round; the final round bypasses MixColumns.
module aes_round
    import aes_pkg::*;
(
    input  logic [BLK_W-1:0] state_in,
    input  logic [BLK_W-1:0] round_key,
    input  logic             last,
    output logic [BLK_W-1:0] state_out
);

    logic [BLK_W-1:0] sub_bytes;
    logic [BLK_W-1:0] shifted;
    logic [BLK_W-1:0] mixed;

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        sbox u_sbox (
            .byte_in  (state_in[8*i +: 8]),
            .byte_out (sub_bytes[8*i +: 8])
        );
    end

    assign shifted   = shift_rows(sub_bytes);
    assign mixed     = mix_columns(shifted);
    assign state_out = (last ? shifted : mixed) ^ round_key;

endmodule

// File: rtl/sbox.sv
// AES S-box: GF(2^8) inverse (x^254, 0 -> 0) followed by the affine map.
module sbox
    import aes_pkg::*;
(
    input  logic [7:0] byte_in,
    output logic [7:0] byte_out
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    logic [7:0] sq;
    logic [7:0] inv;

    // x^254 = product of x^(2^i) for i = 1..7
    always_comb begin
        sq  = byte_in;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
    end

    assign byte_out = inv
                    ^ {inv[6:0], inv[7]}
                    ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]}
                    ^ 8'h63;

endmodule

// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryptor: whitening on accept, then one round per clock, valid/ready both sides.
module aes128_encrypt_iter
    import aes_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BLK_W-1:0]    plaintext,
    input  logic [BLK_W-1:0]    key_in,
    input  logic [NR*BLK_W-1:0] round_keys,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BLK_W-1:0]    ciphertext,
    output logic                busy
);

    aes_fsm_t         fsm_r;
    logic [3:0]       round_r;
    logic [BLK_W-1:0] state_r;
    logic [BLK_W-1:0] round_key;
    logic [BLK_W-1:0] round_out;
    logic             last_round;

    // Unreachable counter values (0, 11..15) fall through to the final round.
    assign last_round = (round_r >= 4'(NR)) || (round_r == 4'd0);

    always_comb begin
        round_key = round_keys[NR*BLK_W-1 -: BLK_W];
        for (int n = 1; n < NR; n++) begin
            if (round_r == 4'(n)) round_key = round_keys[BLK_W*n-1 -: BLK_W];
        end
    end

    aes_round u_round (
        .state_in  (state_r),
        .round_key (round_key),
        .last      (last_round),
        .state_out (round_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_r   <= IDLE;
            round_r <= '0;
            state_r <= '0;
        end else begin
            case (fsm_r)
                IDLE: begin
                    if (in_valid) begin
                        state_r <= plaintext ^ key_in;
                        round_r <= 4'd1;
                        fsm_r   <= ROUND;
                    end
                end
                ROUND: begin
                    state_r <= round_out;
                    round_r <= round_r + 4'd1;
                    if (last_round) fsm_r <= DONE;
                end
                DONE: begin
                    if (out_ready) fsm_r <= IDLE;
                end
                default: fsm_r <= IDLE;
            endcase
        end
    end

    assign in_ready   = (fsm_r == IDLE);
    assign out_valid  = (fsm_r == DONE);
    assign busy       = (fsm_r != IDLE);
    assign ciphertext = state_r;

endmodule
